// File: rtl/xbar_rr_scheduler_pkg.sv
// xbar_sched_pkg: shared widths, discard code and destination decode for the crossbar scheduler
package xbar_sched_pkg;

    localparam int DEST_DISCARD = 0;

    typedef struct packed {
        logic       valid;
        logic [7:0] idx;
    } dec_t;

    function automatic int dest_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic dec_t dest_decode(input logic [63:0] word, input int dw, input int n);
        dec_t r;
        int   d;
        d       = int'(word & ((64'd1 << dw) - 64'd1));
        r.valid = (d != DEST_DISCARD) && (d <= n);
        r.idx   = r.valid ? 8'(d - 1) : 8'd0;
        return r;
    endfunction

endpackage

// File: rtl/xbar_rr_scheduler_rr_arbiter.sv
// rr_arbiter: one-output arbiter, round-robin with XBAR_SCHED_RR_EN, fixed lowest-index priority otherwise
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
`ifdef XBAR_SCHED_RR_EN
    input  logic             clk,
    input  logic             reset,
`endif
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

`ifdef XBAR_SCHED_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // first requester scanning cyclically from the pointer; pointer moves past the winner
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_vld && req[(int'(ptr_q) + k) % N]) begin
                gnt_vld                      = 1'b1;
                gnt_idx                      = IDX_W'((int'(ptr_q) + k) % N);
                gnt[(int'(ptr_q) + k) % N]   = 1'b1;
            end
        end
        ptr_d = gnt_vld ? ((int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
    end

    // pointer register, cleared by reset
    always_ff @(posedge clk) begin
        ptr_q <= reset ? '0 : ptr_d;
    end
`else
    // lowest requesting index wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_vld && req[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(k);
                gnt[k]  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/xbar_rr_scheduler.sv
// xbar_rr_scheduler: per-output crossbar scheduler with discard and pop hold; XBAR_SCHED_RR_EN selects round-robin
module xbar_rr_scheduler
    import xbar_sched_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int DATA_W    = 8,
    parameter int DEST_W    = dest_w(NUM_PORTS),
    parameter int IDX_W     = idx_w(NUM_PORTS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]   data,
    input  logic [NUM_PORTS-1:0]               empty,
    input  logic [NUM_PORTS-1:0]               out_ready,
    output logic [NUM_PORTS-1:0]               rdreq,
    output logic [NUM_PORTS-1:0][IDX_W-1:0]    sel,
    output logic [NUM_PORTS-1:0]               out_vld,
    output logic [NUM_PORTS-1:0]               drop
);

    logic [NUM_PORTS-1:0]            rdreq_q, rdreq_d, vld_q, vld_d, drop_q, drop_d;
    logic [NUM_PORTS-1:0][IDX_W-1:0] sel_q, sel_d;
    logic [NUM_PORTS-1:0]            elig, disc, gvld;
    logic [NUM_PORTS-1:0]            req  [NUM_PORTS];
    logic [NUM_PORTS-1:0]            gnt  [NUM_PORTS];
    logic [IDX_W-1:0]                gidx [NUM_PORTS];

    // decode head words; a word popped last cycle is held off so the stale head is not popped twice
    always_comb begin
        dec_t r;
        r    = '0;
        elig = '0;
        disc = '0;
        for (int o = 0; o < NUM_PORTS; o++) req[o] = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            r       = dest_decode(64'(data[i]), DEST_W, NUM_PORTS);
            elig[i] = !empty[i] && !rdreq_q[i];
            disc[i] = elig[i] && !r.valid;
            for (int o = 0; o < NUM_PORTS; o++)
                req[o][i] = elig[i] && r.valid && (r.idx == 8'(o)) && out_ready[o];
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
        rr_arbiter #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_arb (
`ifdef XBAR_SCHED_RR_EN
            .clk     (clk),
            .reset   (reset),
`endif
            .req     (req[g]),
            .gnt     (gnt[g]),
            .gnt_idx (gidx[g]),
            .gnt_vld (gvld[g])
        );
    end

    // merge discards and grants into pops; sel keeps its last value on idle outputs
    always_comb begin
        rdreq_d = disc;
        drop_d  = disc;
        vld_d   = gvld;
        sel_d   = sel_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            rdreq_d  = rdreq_d | gnt[o];
            sel_d[o] = gvld[o] ? gidx[o] : sel_q[o];
        end
    end

    // registered decision outputs; reset drops any in-flight grant
    always_ff @(posedge clk) begin
        if (reset) begin
            rdreq_q <= '0;
            vld_q   <= '0;
            drop_q  <= '0;
            sel_q   <= '0;
        end else begin
            rdreq_q <= rdreq_d;
            vld_q   <= vld_d;
            drop_q  <= drop_d;
            sel_q   <= sel_d;
        end
    end

    assign rdreq   = rdreq_q;
    assign out_vld = vld_q;
    assign drop    = drop_q;
    assign sel     = sel_q;

endmodule

// File: tb/tb_xbar_rr_scheduler.sv
// tb_xbar_rr_scheduler: randomized + directed scoreboard bench against a behavioural scheduling model
module tb_xbar_rr_scheduler;

    localparam int N = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0][7:0]   data;
    logic [N-1:0]        empty, out_ready, rdreq, out_vld, drop;
    logic [N-1:0][1:0]   sel;

    typedef struct {
        logic [2:0] rd;
        logic [2:0] vld;
        logic [2:0] drp;
        logic [5:0] sl;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    bit   done    = 0;

    logic [2:0] m_hold;
    int         m_ptr [N];
    int         m_sel [N];

    xbar_rr_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .empty     (empty),
        .out_ready (out_ready),
        .rdreq     (rdreq),
        .sel       (sel),
        .out_vld   (out_vld),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic model(output exp_t x);
        int d [N];
        bit el [N];
        x.rd  = '0;
        x.vld = '0;
        x.drp = '0;
        if (reset) begin
            m_hold = '0;
            for (int o = 0; o < N; o++) begin
                m_ptr[o] = 0;
                m_sel[o] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                d[i]  = int'(data[i][1:0]);
                el[i] = !empty[i] && !m_hold[i];
                if (el[i] && (d[i] == 0 || d[i] > N)) begin
                    x.rd[i]  = 1'b1;
                    x.drp[i] = 1'b1;
                end
            end
            for (int o = 0; o < N; o++) begin
                for (int k = 0; k < N; k++) begin
`ifdef XBAR_SCHED_RR_EN
                    int c = (m_ptr[o] + k) % N;
`else
                    int c = k;
`endif
                    if (!x.vld[o] && out_ready[o] && el[c] && d[c] == o + 1) begin
                        x.vld[o] = 1'b1;
                        x.rd[c]  = 1'b1;
                        m_sel[o] = c;
                        m_ptr[o] = (c + 1) % N;
                    end
                end
            end
            m_hold = x.rd;
        end
        for (int o = 0; o < N; o++) x.sl[o*2 +: 2] = 2'(m_sel[o]);
    endtask

    task automatic step(input logic [N-1:0][7:0] d, input logic [2:0] e, input logic [2:0] r, input logic rs);
        exp_t x;
        @(negedge clk);
        data      = d;
        empty     = e;
        out_ready = r;
        reset     = rs;
        model(x);
        q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // monitor: pops one expectation per registered output cycle
    initial begin
        exp_t x;
        while (!done || q.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("rdreq", {3'b0, rdreq}, {3'b0, x.rd});
                chk("out_vld", {3'b0, out_vld}, {3'b0, x.vld});
                chk("drop", {3'b0, drop}, {3'b0, x.drp});
                chk("sel", sel, x.sl);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1);
    end

    initial begin
        logic [N-1:0][7:0] rd;
        m_hold = '0;
        reset  = 1'b1;
        repeat (2) step({8'h00, 8'h00, 8'h00}, 3'b111, 3'b111, 1'b1);
        step({8'h03, 8'h02, 8'h01}, 3'b000, 3'b111, 1'b0);
        step({8'h03, 8'h02, 8'h01}, 3'b000, 3'b111, 1'b0);
        step({8'h03, 8'h02, 8'h01}, 3'b111, 3'b111, 1'b0);
        repeat (12) step({8'h01, 8'h01, 8'h01}, 3'b000, 3'b111, 1'b0);
        step({8'h00, 8'h00, 8'h00}, 3'b111, 3'b111, 1'b0);
        repeat (5) step({8'h00, 8'h00, 8'h02}, 3'b110, 3'b101, 1'b0);
        repeat (3) step({8'h00, 8'h00, 8'h02}, 3'b110, 3'b111, 1'b0);
        step({8'h00, 8'h00, 8'h00}, 3'b111, 3'b111, 1'b0);
        step({8'h00, 8'h00, 8'h00}, 3'b011, 3'b111, 1'b0);
        step({8'h7C, 8'h00, 8'h00}, 3'b111, 3'b111, 1'b0);
        step({8'h7C, 8'h00, 8'h00}, 3'b011, 3'b111, 1'b0);
        step({8'h00, 8'h00, 8'h00}, 3'b111, 3'b111, 1'b0);
        step({8'h00, 8'h01, 8'h00}, 3'b111, 3'b111, 1'b0);
        step({8'h00, 8'h01, 8'h01}, 3'b110, 3'b111, 1'b0);
        step({8'h00, 8'h01, 8'h01}, 3'b000, 3'b111, 1'b1);
        step({8'h01, 8'h01, 8'h01}, 3'b000, 3'b111, 1'b0);
        repeat (4) step({8'h01, 8'h01, 8'h01}, 3'b000, 3'b111, 1'b0);
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) rd[i] = 8'($urandom);
            step(rd, 3'($urandom) & 3'($urandom), 3'($urandom) | 3'($urandom),
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end
        step({8'h00, 8'h00, 8'h00}, 3'b111, 3'b111, 1'b0);
        done = 1;
    end

endmodule
